// File: rtl/axi_ram_slave_if.sv
// AXI4 write/read channel bundle between an upstream master and the RAM slave endpoint.
// STRB_WIDTH is derived from DATA_WIDTH rather than passed as a parameter.
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a word-wide RAM; independent write and read FSMs share the array
// and service INCR/FIXED bursts (WRAP behaves as INCR). Responses are always OKAY.
module axi_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input logic clk,
  input logic rst_n,
  axi_ram_slave_if.slave s_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int WORD_W     = ADDR_WIDTH - OFFS;
  localparam int DEPTH      = 2 ** WORD_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t            w_state;
  logic [WORD_W-1:0]   w_word;
  logic [7:0]          w_cnt;
  logic                w_fixed;
  logic                awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0] bid_q;

  r_state_t              r_state;
  logic [WORD_W-1:0]     r_word;
  logic [7:0]            r_cnt;
  logic                  r_fixed, r_more;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, r_adv;
  assign aw_hs = s_axi.awvalid && awready_q;
  assign w_hs  = s_axi.wvalid && wready_q;
  assign ar_hs = s_axi.arvalid && arready_q;
  assign r_adv = !rvalid_q || s_axi.rready;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  // Burst length comes from awlen alone, and the byte offset within a word is dropped.
  logic unused_wlast;
  assign unused_wlast = s_axi.wlast;
  if (OFFS > 0) begin : g_addr_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, s_axi.awaddr[OFFS-1:0], s_axi.araddr[OFFS-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_word    <= '0;
      w_cnt     <= '0;
      w_fixed   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            w_word    <= s_axi.awaddr[ADDR_WIDTH-1:OFFS];
            w_cnt     <= s_axi.awlen;
            w_fixed   <= (s_axi.awburst == 2'b00);
            bid_q     <= s_axi.awid;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (!w_fixed) w_word <= w_word + WORD_W'(1);
            w_cnt <= w_cnt - 8'd1;
            if (w_cnt == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi.wstrb[i]) mem[w_word][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  // The R output register reloads whenever it is empty or being consumed; r_more marks
  // beats still to fetch so the final accepted beat can drop rvalid and return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_word    <= '0;
      r_cnt     <= '0;
      r_fixed   <= 1'b0;
      r_more    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            r_word    <= s_axi.araddr[ADDR_WIDTH-1:OFFS];
            r_cnt     <= s_axi.arlen;
            r_fixed   <= (s_axi.arburst == 2'b00);
            rid_q     <= s_axi.arid;
            r_more    <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_adv) begin
            if (r_more) begin
              rdata_q  <= mem[r_word];
              rvalid_q <= 1'b1;
              rlast_q  <= (r_cnt == 8'd0);
              if (!r_fixed) r_word <= r_word + WORD_W'(1);
              if (r_cnt == 8'd0) r_more <= 1'b0;
              else               r_cnt  <= r_cnt - 8'd1;
            end else begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised bench for axi_ram_slave: a byte-array reference model feeds B/R scoreboard
// queues at issue time, and a negedge monitor pops and compares on every handshake.
module tb_axi_ram_slave;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int IW    = 8;
  localparam int LIMIT = 2000;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus.slave)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } r_beat_t;

  logic [7:0]    model_mem [0:65535];
  logic [IW-1:0] exp_b [$];
  r_beat_t       exp_r [$];
  logic [DW-1:0] wdata_buf [0:255];
  logic [3:0]    wstrb_buf [0:255];
  logic          pat_q [$];
  int            checks = 0;
  int            failures = 0;
  int            ready_mode = 0;

  function automatic void check_output(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endfunction

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timeout_fail(string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake within %0d cycles", name, LIMIT);
    finish_run();
  endtask

  task automatic check_reset_outputs(string tag);
    check_output({tag, "_ctrl"},
                 {58'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 64'd0);
    check_output({tag, "_rdata"}, bus.rdata, 64'd0);
    check_output({tag, "_ids"}, {bus.bid, bus.rid}, 64'd0);
  endtask

  // Ready generator: a queued pattern takes priority, otherwise held high or random.
  initial begin
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pat_q.size() > 0)  bus.rready = pat_q.pop_front();
      else if (ready_mode == 1) bus.rready = 1'($urandom_range(0, 1));
      else                   bus.rready = 1'b1;
      bus.bready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: inputs are stable at negedge, so valid && ready here means a handshake at the next edge.
  initial begin
    logic          r_stall, b_stall;
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_rid, held_bid;
    logic          held_last;
    logic [IW-1:0] eb;
    r_beat_t       er;
    r_stall = 1'b0;
    b_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (r_stall) begin
          check_output("r_stall_valid", bus.rvalid, 1);
          check_output("r_stall_data", bus.rdata, held_data);
          check_output("r_stall_id_last", {bus.rid, bus.rlast}, {held_rid, held_last});
        end
        if (b_stall) begin
          check_output("b_stall_hold", {bus.bvalid, bus.bid}, {1'b1, held_bid});
        end
        if (bus.bvalid && bus.bready) begin
          if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_b actual bid=%0h expected no response", bus.bid);
          end else begin
            eb = exp_b.pop_front();
            check_output("b_id", bus.bid, eb);
            check_output("b_resp", bus.bresp, 0);
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_r actual rid=%0h rdata=%0h expected no beat", bus.rid, bus.rdata);
          end else begin
            er = exp_r.pop_front();
            check_output("r_data", bus.rdata, er.data);
            check_output("r_id", bus.rid, er.id);
            check_output("r_last", bus.rlast, er.last);
            check_output("r_resp", bus.rresp, 0);
          end
        end
        r_stall   = bus.rvalid && !bus.rready;
        b_stall   = bus.bvalid && !bus.bready;
        held_data = bus.rdata;
        held_rid  = bus.rid;
        held_last = bus.rlast;
        held_bid  = bus.bid;
      end
    end
  end

  // Write burst from wdata_buf/wstrb_buf; abort_beats >= 0 pulls reset after that many beats.
  task automatic apply_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input logic [1:0] burst, input int abort_beats);
    logic [AW-1:0] a;
    int n;
    a = {addr[AW-1:2], 2'b00};
    @(posedge clk);
    #1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (++n > LIMIT) timeout_fail("aw_handshake");
    end while (!bus.awready);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == abort_beats) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        repeat (3) @(posedge clk);
        #1;
        check_output("abort_no_b", bus.bvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("abort_awready", bus.awready, 1);
        check_output("abort_no_b_after", bus.bvalid, 0);
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.wdata  = wdata_buf[b];
      bus.wstrb  = wstrb_buf[b];
      bus.wlast  = (b == len);
      bus.wvalid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        if (++n > LIMIT) timeout_fail("w_handshake");
      end while (!bus.wready);
      for (int i = 0; i < 4; i++) begin
        if (wstrb_buf[b][i]) model_mem[a + i] = wdata_buf[b][8*i +: 8];
      end
      if (b == len) exp_b.push_back(id);
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      if (b == len) check_output("b_latency", bus.bvalid, 1);
      if (burst != FIXED) a = a + 16'd4;
    end
    n = 0;
    while (exp_b.size() != 0) begin
      @(posedge clk);
      if (++n > LIMIT) timeout_fail("b_response");
    end
    @(posedge clk);
  endtask

  // Read burst; expected beats come from the model at issue time.
  task automatic apply_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst, input bit timing, input bit stall_pat);
    logic [AW-1:0] a;
    r_beat_t e;
    int n;
    a = {addr[AW-1:2], 2'b00};
    for (int b = 0; b <= len; b++) begin
      e.id   = id;
      e.data = {model_mem[a + 3], model_mem[a + 2], model_mem[a + 1], model_mem[a]};
      e.last = (b == len);
      exp_r.push_back(e);
      if (burst != FIXED) a = a + 16'd4;
    end
    @(posedge clk);
    #1;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (++n > LIMIT) timeout_fail("ar_handshake");
    end while (!bus.arready);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    if (stall_pat) begin
      pat_q.push_back(1'b1);
      pat_q.push_back(1'b0);
      pat_q.push_back(1'b0);
      pat_q.push_back(1'b1);
      pat_q.push_back(1'b1);
      pat_q.push_back(1'b1);
    end
    if (timing) begin
      check_output("r_not_yet_valid", bus.rvalid, 0);
      for (int b = 0; b <= len; b++) begin
        @(posedge clk);
        #1;
        check_output("r_beat_valid", bus.rvalid, 1);
        check_output("r_last_position", bus.rlast, (b == len));
      end
      @(posedge clk);
      #1;
      check_output("r_burst_done", bus.rvalid, 0);
    end
    n = 0;
    while (exp_r.size() != 0) begin
      @(posedge clk);
      if (++n > LIMIT) timeout_fail("r_beats");
    end
    @(posedge clk);
  endtask

  initial begin
    #500000;
    timeout_fail("global_watchdog");
  end

  initial begin
    int len;
    logic [1:0] bu;
    logic [AW-1:0] addr;
    rst_n       = 1'b1;
    bus.awid    = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.arid    = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("post_reset_ready", {bus.awready, bus.arready}, 2'b11);

    // Fill both ends of the address space so every later read hits known data.
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 256; b++) begin
        wdata_buf[b] = $urandom;
        wstrb_buf[b] = 4'hF;
      end
      apply_write(8'h01, (r == 0) ? 16'h0000 : 16'hFC00, 255, INCR, -1);
    end

    wdata_buf[0] = 32'hDEADBEEF; wstrb_buf[0] = 4'hF;
    apply_write(8'd5, 16'h0010, 0, INCR, -1);
    apply_read(8'd3, 16'h0010, 0, INCR, 1'b1, 1'b0);

    for (int b = 0; b < 4; b++) begin
      wdata_buf[b] = 32'(b + 1);
      wstrb_buf[b] = 4'hF;
    end
    apply_write(8'd7, 16'h0100, 3, INCR, -1);
    apply_read(8'd8, 16'h0100, 3, INCR, 1'b1, 1'b0);

    wdata_buf[0] = 32'h11223344; wstrb_buf[0] = 4'hF;
    apply_write(8'd9, 16'h0040, 0, INCR, -1);
    wdata_buf[0] = 32'hAABBCCDD; wstrb_buf[0] = 4'b0010;
    apply_write(8'd10, 16'h0040, 0, INCR, -1);
    apply_read(8'd11, 16'h0042, 0, INCR, 1'b0, 1'b0);

    wdata_buf[0] = 32'hA; wdata_buf[1] = 32'hB; wdata_buf[2] = 32'hC;
    wstrb_buf[0] = 4'hF;  wstrb_buf[1] = 4'hF;  wstrb_buf[2] = 4'hF;
    apply_write(8'd12, 16'h0020, 2, FIXED, -1);
    apply_read(8'd13, 16'h0020, 1, INCR, 1'b0, 1'b0);
    wdata_buf[0] = 32'h0BADF00D; wdata_buf[1] = 32'hC0FFEE11;
    apply_write(8'd14, 16'hFFFC, 1, INCR, -1);
    apply_read(8'd15, 16'hFFFC, 1, INCR, 1'b0, 1'b0);

    apply_read(8'd16, 16'h0100, 3, INCR, 1'b0, 1'b1);

    for (int b = 0; b < 4; b++) begin
      wdata_buf[b] = $urandom;
      wstrb_buf[b] = 4'hF;
    end
    apply_write(8'd17, 16'h0080, 3, INCR, 2);
    wdata_buf[0] = 32'h5A5A1234; wstrb_buf[0] = 4'hF;
    apply_write(8'd18, 16'h0084, 0, INCR, -1);
    apply_read(8'd19, 16'h0080, 3, INCR, 1'b0, 1'b0);

    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      len  = $urandom_range(0, 7);
      bu   = (t % 3 == 0) ? FIXED : ((t % 3 == 1) ? INCR : WRAP);
      addr = 16'($urandom_range(0, 'h400) - 'h40);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wdata_buf[b] = $urandom;
          wstrb_buf[b] = 4'($urandom_range(0, 15));
        end
        apply_write(8'($urandom), addr, len, bu, -1);
      end else begin
        apply_read(8'($urandom), addr, len, bu, 1'b0, 1'b0);
      end
    end

    // Overlapping read and write bursts on disjoint regions.
    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < 8; b++) begin
        wdata_buf[b] = $urandom;
        wstrb_buf[b] = 4'hF;
      end
      fork
        apply_write(8'($urandom), 16'(16'h0200 + $urandom_range(0, 'h1C0)), 7, INCR, -1);
        apply_read(8'($urandom), 16'($urandom_range(0, 'h1C0)), 7, INCR, 1'b0, 1'b0);
      join
    end

    ready_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    check_output("b_queue_drained", exp_b.size(), 0);
    check_output("r_queue_drained", exp_r.size(), 0);
    finish_run();
  end
endmodule
